// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/sub sequencer.
// Pure declarations: no latency, no flow control.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int SHAMT_W = 5;
  localparam int SH_W    = MAN_W + 2;
  localparam int NE_W    = EXP_W + 2;

  localparam logic [31:0]        QNAN      = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]   EXP_MAX   = 8'hFF;
  localparam logic [SHAMT_W-1:0] SHIFT_MAX = '1;
  localparam logic               SH_LEFT   = 1'b0;
  localparam logic               SH_RIGHT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp_t;

  // Denormals are flushed: a zero exponent always unpacks to a zero mantissa.
  function automatic logic [SH_W-1:0] unpack_mant(input fp_t f);
    return (f.exp == '0) ? '0 : {2'b01, f.frac};
  endfunction

endpackage

// File: rtl/fp_shift_unit.sv
// Combinational 25-bit barrel shifter, one log stage per amount bit.
// Zero latency; no flow control, the caller owns dir/amt/data every cycle.
module fp_shift_unit
  import fp_pkg::*;
(
  input  logic               dir,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [SH_W-1:0]    data,
  output logic [SH_W-1:0]    q
);

  logic [SHAMT_W:0][SH_W-1:0] stage;

  assign stage[0] = data;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    assign stage[i+1] = !amt[i]          ? stage[i] :
                        (dir == SH_RIGHT) ? (stage[i] >> (2**i)) :
                                            (stage[i] << (2**i));
  end

  assign q = stage[SHAMT_W];

endmodule

// File: rtl/fp_add_shift_sequencer.sv
// Multi-cycle IEEE-754 single add/sub sharing one shifter for align and normalise; out_valid 4 clks after accept (specials 2).
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready.
module fp_add_shift_sequencer
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        busy
);

  state_t state, state_nxt;

  fp_t              op_a, op_b;
  logic [SH_W-1:0]  mx, my, sum;
  logic [EXP_W-1:0] ex;
  logic             rsign, eff_sub;
  logic [31:0]      result_q;
  logic             ovf_q, unf_q;

  logic accept;
  assign accept = in_valid & in_ready;

  // Operand classification, special-case resolution and swap for ALIGN
  logic               a_nan, b_nan, a_inf, b_inf, special;
  logic [31:0]        special_res;
  logic               swap;
  fp_t                fx, fy;
  logic [EXP_W-1:0]   ediff;
  logic [SHAMT_W-1:0] align_amt;

  always_comb begin
    a_nan   = (op_a.exp == EXP_MAX) && (op_a.frac != '0);
    b_nan   = (op_b.exp == EXP_MAX) && (op_b.frac != '0);
    a_inf   = (op_a.exp == EXP_MAX) && (op_a.frac == '0);
    b_inf   = (op_b.exp == EXP_MAX) && (op_b.frac == '0);
    special = a_nan | b_nan | a_inf | b_inf;

    if (a_nan || b_nan || (a_inf && b_inf && (op_a.sign != op_b.sign)))
      special_res = QNAN;
    else if (a_inf)
      special_res = op_a;
    else
      special_res = op_b;

    swap      = {op_b.exp, op_b.frac} > {op_a.exp, op_a.frac};
    fx        = swap ? op_b : op_a;
    fy        = swap ? op_a : op_b;
    ediff     = fx.exp - fy.exp;
    align_amt = (|ediff[EXP_W-1:SHAMT_W]) ? SHIFT_MAX : ediff[SHAMT_W-1:0];
  end

  // Leading zeros below the carry bit; only meaningful when sum[24]==0 and sum!=0
  logic [SHAMT_W-1:0] lz;
  logic               lz_found;

  always_comb begin
    lz       = '0;
    lz_found = 1'b0;
    for (int i = SH_W - 2; i >= 0; i--) begin
      if (!lz_found) begin
        if (sum[i]) lz_found = 1'b1;
        else        lz       = lz + 1'b1;
      end
    end
  end

  logic               sh_dir;
  logic [SHAMT_W-1:0] sh_amt;
  logic [SH_W-1:0]    sh_data, sh_q;

  always_comb begin
    sh_dir  = SH_RIGHT;
    sh_amt  = '0;
    sh_data = '0;
    case (state)
      ALIGN: begin
        sh_dir  = SH_RIGHT;
        sh_amt  = align_amt;
        sh_data = unpack_mant(fy);
      end
      NORM: begin
        sh_data = sum;
        if (sum[SH_W-1]) begin
          sh_dir = SH_RIGHT;
          sh_amt = SHAMT_W'(1);
        end else begin
          sh_dir = SH_LEFT;
          sh_amt = lz;
        end
      end
      default: ;
    endcase
  end

  fp_shift_unit u_shift (
    .dir  (sh_dir),
    .amt  (sh_amt),
    .data (sh_data),
    .q    (sh_q)
  );

  // Exponent is carried two bits wider so that saturation and flush are plain compares
  logic [NE_W-1:0] nexp;
  logic [31:0]     norm_res;
  logic            norm_ovf, norm_unf;

  always_comb begin
    if (sum[SH_W-1])
      nexp = {2'b00, ex} + NE_W'(1);
    else
      nexp = {2'b00, ex} - {{(NE_W-SHAMT_W){1'b0}}, lz};

    norm_ovf = 1'b0;
    norm_unf = 1'b0;
    if (sum == '0) begin
      norm_res = '0;
    end else if (!nexp[NE_W-1] && (nexp[NE_W-2:0] >= {1'b0, EXP_MAX})) begin
      norm_res = {rsign, EXP_MAX, {MAN_W{1'b0}}};
      norm_ovf = 1'b1;
    end else if (nexp[NE_W-1] || (nexp == '0)) begin
      norm_res = '0;
      norm_unf = 1'b1;
    end else begin
      norm_res = {rsign, nexp[EXP_W-1:0], sh_q[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ALIGN;
      ALIGN:   state_nxt = special ? DONE : ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      mx       <= '0;
      my       <= '0;
      sum      <= '0;
      ex       <= '0;
      rsign    <= 1'b0;
      eff_sub  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a <= a;
          op_b <= {b[31] ^ sub, b[30:0]};
        end
        ALIGN: begin
          if (special) begin
            result_q <= special_res;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
          end else begin
            mx      <= unpack_mant(fx);
            my      <= sh_q;
            ex      <= fx.exp;
            rsign   <= fx.sign;
            eff_sub <= fx.sign ^ fy.sign;
          end
        end
        ADD: sum <= eff_sub ? (mx - my) : (mx + my);
        NORM: begin
          result_q <= norm_res;
          ovf_q    <= norm_ovf;
          unf_q    <= norm_unf;
        end
        DONE: if (out_ready) begin
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_add_shift_sequencer.sv
// Scoreboard bench for fp_add_shift_sequencer: expected results queued at issue, compared at out_valid.
module tb_fp_add_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  exp_t exp_q[$];

  fp_add_shift_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub, output bit ok);
    int n = 0;
    a = ia; b = ib; sub = isub; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency counts rising edges from the accepting edge to the first one that shows out_valid.
  task automatic collect(output logic [31:0] r, output logic o, output logic u, output int lat, output bit to);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    to = !out_valid;
    r  = result;
    o  = overflow;
    u  = underflow;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, result, overflow, underflow} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b res=%h ovf=%b unf=%b, want 1 0 0 00000000 0 0",
               in_ready, out_valid, busy, result, overflow, underflow);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith();
    vec_t tbl [7];
    exp_t e;
    logic [31:0] r;
    logic o, u;
    int lat;
    bit to, ok;
    tbl = '{
      '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 1'b0, 1'b0, 4},
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 4},
      '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 4},
      '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 4},
      '{32'h40000000, 32'h3F000000, 1'b1, 32'h3FC00000, 1'b0, 1'b0, 4},
      '{32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 4},
      '{32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 1'b0, 1'b1, 4}
    };
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{tbl[i].res, tbl[i].ovf, tbl[i].unf, tbl[i].lat});
      issue(tbl[i].a, tbl[i].b, tbl[i].sub, ok);
      collect(r, o, u, lat, to);
      e = exp_q.pop_front();
      n_checks++;
      if (r !== e.res) $display("FAIL arith[%0d] result: got %h want %h", i, r, e.res);
      else n_pass++;
      n_checks++;
      if ({o, u} !== {e.ovf, e.unf}) $display("FAIL arith[%0d] flags: got ovf=%b unf=%b want ovf=%b unf=%b", i, o, u, e.ovf, e.unf);
      else n_pass++;
      n_checks++;
      if (!ok || to || lat != e.lat) $display("FAIL arith[%0d] latency: got %0d (ok=%b timeout=%b) want %0d", i, lat, ok, to, e.lat);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    logic [31:0] r;
    logic o, u;
    int lat;
    bit to, ok;
    exp_q.push_back('{32'h7F800000, 1'b1, 1'b0, 4});
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, ok);
    collect(r, o, u, lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (r !== e.res) $display("FAIL overflow result: got %h want %h", r, e.res);
    else n_pass++;
    n_checks++;
    if ({o, u} !== {e.ovf, e.unf} || to || !ok) $display("FAIL overflow flags: got ovf=%b unf=%b timeout=%b want ovf=1 unf=0", o, u, to);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, overflow, in_ready} !== 3'b001) $display("FAIL overflow_clear: got vld=%b ovf=%b rdy=%b want 0 0 1", out_valid, overflow, in_ready);
    else n_pass++;
  endtask

  task automatic test_specials();
    vec_t tbl [5];
    exp_t e;
    logic [31:0] r;
    logic o, u;
    int lat;
    bit to, ok;
    tbl = '{
      '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 2},
      '{32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 2},
      '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b0, 1'b0, 2},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0, 2},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 2}
    };
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{tbl[i].res, tbl[i].ovf, tbl[i].unf, tbl[i].lat});
      issue(tbl[i].a, tbl[i].b, tbl[i].sub, ok);
      collect(r, o, u, lat, to);
      e = exp_q.pop_front();
      n_checks++;
      if (r !== e.res || {o, u} !== {e.ovf, e.unf}) $display("FAIL special[%0d] result: got %h ovf=%b unf=%b want %h 0 0", i, r, o, u, e.res);
      else n_pass++;
      n_checks++;
      if (!ok || to || lat != e.lat) $display("FAIL special[%0d] latency: got %0d (timeout=%b) want %0d", i, lat, to, e.lat);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure_back_to_back();
    exp_t e;
    logic [31:0] r;
    logic o, u;
    int lat;
    bit to, ok;
    bit stable;
    out_ready = 1'b0;
    exp_q.push_back('{32'h40700000, 1'b0, 1'b0, 4});
    issue(32'h3FC00000, 32'h40100000, 1'b0, ok);
    collect(r, o, u, lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (to || r !== e.res) $display("FAIL backpressure result: got %h (timeout=%b) want %h", r, to, e.res);
    else n_pass++;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (result !== e.res || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL backpressure hold: got res=%h vld=%b rdy=%b want %h 1 0", result, out_valid, in_ready, e.res);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL backpressure release: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    else n_pass++;
    exp_q.push_back('{32'h40700000, 1'b0, 1'b0, 4});
    issue(32'h3FC00000, 32'h40100000, 1'b0, ok);
    collect(r, o, u, lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (r !== e.res || {o, u} !== 2'b00) $display("FAIL back_to_back result: got %h ovf=%b unf=%b want %h 0 0", r, o, u, e.res);
    else n_pass++;
    n_checks++;
    if (!ok || to || lat != e.lat) $display("FAIL back_to_back latency: got %0d want %0d", lat, e.lat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    logic [31:0] r;
    logic o, u;
    int lat;
    bit to, ok;
    bit stray;
    issue(32'h3FC00000, 32'h40100000, 1'b0, ok);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL reset_mid precondition: got busy=%b vld=%b want 1 0", busy, out_valid);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, result, overflow, underflow} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0})
      $display("FAIL reset_mid outputs: rdy=%b vld=%b busy=%b res=%h ovf=%b unf=%b want 1 0 0 00000000 0 0",
               in_ready, out_valid, busy, result, overflow, underflow);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray) $display("FAIL reset_mid stray out_valid: got 1 want 0");
    else n_pass++;
    exp_q.push_back('{32'h40700000, 1'b0, 1'b0, 4});
    issue(32'h3FC00000, 32'h40100000, 1'b0, ok);
    collect(r, o, u, lat, to);
    e = exp_q.pop_front();
    n_checks++;
    if (r !== e.res || {o, u} !== 2'b00 || to || !ok || lat != e.lat)
      $display("FAIL reset_mid recovery: got %h ovf=%b unf=%b lat=%0d want %h 0 0 lat=%0d", r, o, u, lat, e.res, e.lat);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_overflow();
    test_specials();
    test_backpressure_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
